// File: rtl/conv_pkg.sv
// Shared constants and state encoding for the convolution result
// transmitter and its helpers.
package conv_pkg;

  localparam int DATA_W   = 8;
  localparam int OUT_COLS = 6;
  localparam int OUT_ROWS = 6;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    CHK,
    DONE
  } tx_state_t;

endpackage

// File: rtl/conv_sync_fifo.sv
// Parameterised synchronous FIFO; head is read straight from storage
// registers. Caller guarantees no write when full unless reading.
module conv_sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [W-1:0]             wr_data,
  input  logic                     rd_en,
  output logic [W-1:0]             rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  assign rd_data = mem[rd_ptr];
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);

  // Storage, power-of-two pointers wrap naturally, occupancy count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      unique case (1'b1)
        (wr_en && !rd_en): count <= count + 1'b1;
        (rd_en && !wr_en): count <= count - 1'b1;
        default:           count <= count;
      endcase
    end
  end

endmodule

// File: rtl/conv_result_tx.sv
// Result transmitter: FIFO plus framing FSM with sof/eol/eof markers.
// Optional trailing XOR checksum byte under CONV_TX_CHECKSUM_EN.
module conv_result_tx
  import conv_pkg::*;
#(
  parameter int DATA_W     = conv_pkg::DATA_W,
  parameter int FIFO_DEPTH = 4,
  parameter int OUT_COLS   = conv_pkg::OUT_COLS,
  parameter int OUT_ROWS   = conv_pkg::OUT_ROWS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic [DATA_W-1:0] conv_data,
  input  logic              conv_valid,
  input  logic              tx_ready,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  output logic              tx_sof,
  output logic              tx_eol,
  output logic              tx_eof,
  output logic              overflow,
  output logic              frame_done
);

  localparam int COL_W = $clog2(OUT_COLS + 1);
  localparam int ROW_W = $clog2(OUT_ROWS + 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(OUT_COLS - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(OUT_ROWS - 1);

  tx_state_t state;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;

  logic [DATA_W-1:0] head;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic full;
  logic empty;

  logic is_chk;
  logic xfer;
  logic rd;
  logic wr;
  logic at_eol;
  logic at_eof;
  logic tag_ok;

  assign xfer = ena && tx_valid && tx_ready;
  assign rd   = xfer && !is_chk && !empty;
  assign wr   = ena && conv_valid && (!full || rd);

  conv_sync_fifo #(
    .W     (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr),
    .wr_data (conv_data),
    .rd_en   (rd),
    .rd_data (head),
    .count   (fifo_count),
    .full    (full),
    .empty   (empty)
  );

`ifdef CONV_TX_CHECKSUM_EN
  logic [DATA_W-1:0] csum;

  assign is_chk  = (state == CHK);
  assign tx_data = is_chk ? csum :
                   (tx_valid ? head : '0);

  // Running XOR over the frame; cleared once the checksum byte leaves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum <= '0;
    end else if (ena) begin
      if (is_chk && xfer) csum <= '0;
      else if (rd)        csum <= csum ^ head;
    end
  end
`else
  assign is_chk  = 1'b0;
  assign tx_data = tx_valid ? head : '0;
`endif

  assign tx_valid   = is_chk || (fifo_count != '0);
  assign at_eol     = (col == COL_LAST);
  assign at_eof     = at_eol && (row == ROW_LAST);
  assign tag_ok     = tx_valid && !is_chk;
  assign tx_sof     = tag_ok && (col == '0) && (row == '0);
  assign tx_eol     = tag_ok && at_eol;
  assign tx_eof     = tag_ok && at_eof;
  assign frame_done = (state == DONE);

  // Framing FSM and column/row position of the head byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      col   <= '0;
      row   <= '0;
    end else if (ena) begin
      case (state)
        CHK: begin
          if (xfer) state <= DONE;
        end
        default: begin
          if (rd) begin
            if (at_eof) begin
              col <= '0;
              row <= '0;
`ifdef CONV_TX_CHECKSUM_EN
              state <= CHK;
`else
              state <= DONE;
`endif
            end else begin
              state <= ACTIVE;
              if (at_eol) begin
                col <= '0;
                row <= row + 1'b1;
              end else begin
                col <= col + 1'b1;
              end
            end
          end else if (state == DONE) begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

  // Sticky drop indicator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (ena && conv_valid && full && !rd) begin
      overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_conv_result_tx.sv
// Directed + randomized bench for conv_result_tx with a queue-based
// reference model of the frame stream.
module tb_conv_result_tx;

  localparam int DEPTH = 4;
  localparam int FRAME = 36;
  localparam int COLS  = 6;
`ifdef CONV_TX_CHECKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] conv_data;
  logic       conv_valid;
  logic       tx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_sof;
  logic       tx_eol;
  logic       tx_eof;
  logic       overflow;
  logic       frame_done;

  always #5 clk = ~clk;

  conv_result_tx dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .conv_data  (conv_data),
    .conv_valid (conv_valid),
    .tx_ready   (tx_ready),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_sof     (tx_sof),
    .tx_eol     (tx_eol),
    .tx_eof     (tx_eof),
    .overflow   (overflow),
    .frame_done (frame_done)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] q[$];
  int         k;
  bit         chk_pend;
  bit         done_exp;
  bit         ovf_exp;
  logic [7:0] csum;

  task automatic cmp(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    q.delete();
    k        = 0;
    chk_pend = 1'b0;
    done_exp = 1'b0;
    ovf_exp  = 1'b0;
    csum     = 8'h00;
  endtask

  task automatic check_outputs(string tag);
    bit         ev;
    bit         tg;
    logic [7:0] ed;
    ev = chk_pend || (q.size() != 0);
    tg = ev && !chk_pend;
    ed = chk_pend ? csum : ((q.size() != 0) ? q[0] : 8'h00);
    cmp({tag, ".valid"}, tx_valid, ev);
    cmp({tag, ".data"},  tx_data, ed);
    cmp({tag, ".sof"},   tx_sof, tg && (k == 0));
    cmp({tag, ".eol"},   tx_eol, tg && ((k % COLS) == COLS - 1));
    cmp({tag, ".eof"},   tx_eof, tg && (k == FRAME - 1));
    cmp({tag, ".ovf"},   overflow, ovf_exp);
    cmp({tag, ".done"},  frame_done, done_exp);
  endtask

  task automatic step(string tag, bit en, bit cv,
                      logic [7:0] cd, bit rdy);
    bit ev;
    bit xfer;
    bit rd;
    bit wr;
    ena        = en;
    conv_valid = cv;
    conv_data  = cd;
    tx_ready   = rdy;
    #1;
    check_outputs(tag);
    ev   = chk_pend || (q.size() != 0);
    xfer = en && ev && rdy;
    rd   = xfer && !chk_pend;
    wr   = en && cv && ((q.size() < DEPTH) || rd);
    if (en && cv && !wr) ovf_exp = 1'b1;
    if (en)
      done_exp = xfer && (chk_pend || (!CHK_EN && k == FRAME - 1));
    if (xfer && chk_pend) begin
      chk_pend = 1'b0;
      csum     = 8'h00;
    end else if (rd) begin
      csum = csum ^ q[0];
      void'(q.pop_front());
      if (k == FRAME - 1) begin
        k        = 0;
        chk_pend = CHK_EN;
      end else begin
        k++;
      end
    end
    if (wr) q.push_back(cd);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(string tag);
    rst_n = 1'b0;
    model_clear();
    #1;
    check_outputs(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n      = 1'b1;
    ena        = 1'b0;
    conv_valid = 1'b0;
    conv_data  = 8'h00;
    tx_ready   = 1'b0;
    model_clear();
    @(negedge clk);
    do_reset("reset");

    for (int i = 0; i < FRAME; i++)
      step("frame", 1'b1, 1'b1, 8'(i + 1), 1'b1);
    for (int i = 0; i < 8; i++)
      step("frame_tail", 1'b1, 1'b0, 8'h00, 1'b1);

    step("lat_wr", 1'b1, 1'b1, 8'h11, 1'b1);
    cmp("lat_model_q", q.size(), 1);
    step("lat_rd", 1'b1, 1'b0, 8'h00, 1'b1);
    step("lat_idle", 1'b1, 1'b0, 8'h00, 1'b1);

    for (int i = 0; i < 5; i++)
      step("ovf_fill", 1'b1, 1'b1, 8'(8'hA0 + i), 1'b0);
    for (int i = 0; i < 6; i++)
      step("ovf_drain", 1'b1, 1'b0, 8'h00, 1'b1);

    for (int i = 0; i < 4; i++)
      step("full_fill", 1'b1, 1'b1, 8'(8'hB0 + i), 1'b0);
    for (int i = 0; i < 3; i++)
      step("full_rw", 1'b1, 1'b1, 8'(8'hC0 + i), 1'b1);
    for (int i = 0; i < 6; i++)
      step("full_drain", 1'b1, 1'b0, 8'h00, 1'b1);

    for (int i = 0; i < 120; i++)
      step("stall", !(i >= 40 && i < 43), 1'($urandom_range(0, 1)),
           8'($urandom), 1'(i % 2));

    do_reset("mid_reset");

    for (int i = 0; i < 400; i++)
      step("rand", 1'($urandom_range(0, 7) != 0),
           1'($urandom_range(0, 2) != 0), 8'($urandom),
           1'($urandom_range(0, 3) != 0));
    for (int i = 0; i < 10; i++)
      step("rand_tail", 1'b1, 1'b0, 8'h00, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
